cmu_2way: RTL
=============

// Module: cmu_2way
// PURPOSE
//  Parametrised 2-way set-associative, write-back, write-allocate cache management unit.
//  Sits between the MEM stage and the word-wide memory bus; stalls the pipeline on a miss.
//  Generalises the single-line CMU: configurable set count and line size, plus LRU replacement.
// PARAMETERS
//  LINE_WORDS_WIDTH  2   log2(words per line); line = 2^LINE_WORDS_WIDTH 32-bit words
//  SET_BITS          4   log2(sets); index = addr[SET_BITS+LINE_WORDS_WIDTH+1 : LINE_WORDS_WIDTH+2]
//  TAG_BITS          32-SET_BITS-LINE_WORDS_WIDTH-2 (derived localparam, not overridable)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  addr_rw     in   32  CPU byte address (word aligned; bits[1:0] ignored)
//  en_r        in   1   CPU read request
//  en_w        in   1   CPU write request
//  data_w      in   32  CPU write data
//  data_r      out  32  CPU read data (combinational, valid when stall=0)
//  stall       out  1   hold CPU; request inputs must stay stable while high
//  mem_cs_o    out  1   memory bus select (registered)
//  mem_we_o    out  1   memory bus write (registered)
//  mem_addr_o  out  32  memory word address, bits[1:0]=0 (registered)
//  mem_data_o  out  32  write-back data (registered)
//  mem_data_i  in   32  fill data, sampled when mem_ack_i=1
//  mem_ack_i   in   1   one word transferred this cycle; ignored while mem_cs_o=0
// BEHAVIOUR
//  - Reset: state=S_IDLE, word_count=0, all valid/dirty/LRU bits cleared (data array not cleared);
//    mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0. Applies mid-burst too: burst aborted, dirty data lost.
//  - States: S_IDLE, S_BACK, S_BACK_WAIT, S_FILL, S_FILL_WAIT.
//  - S_IDLE, no request: stall=0. Request with hit in way w: stall=0 same cycle, data_r=word;
//    write updates word + sets dirty[w] at posedge; LRU[set] <= ~w on any hit. en_r&en_w together = write.
//  - S_IDLE miss: stall=1 same cycle. Victim = first invalid way (way0 first), else way LRU[set].
//    Victim valid&dirty -> S_BACK, else -> S_FILL. Victim way latched for whole refill.
//  - S_BACK: cs=1 we=1 addr={victim tag,index,word_count,2'b00}, data_o=victim word;
//    each ack increments word_count; ack on last word -> S_BACK_WAIT (1 cycle, cs=0, word_count=0) -> S_FILL.
//  - S_FILL: cs=1 we=0 addr={addr_rw[31:LINE_WORDS_WIDTH+2],word_count,2'b00}; on ack
//    mem_data_i written to victim word word_count; last ack -> S_FILL_WAIT.
//  - S_FILL_WAIT: victim valid=1, dirty=0, tag=request tag; cs=0; -> S_IDLE, where the held
//    request re-evaluates as a hit (stall drops that cycle; write then sets dirty).
//  - word_count is LINE_WORDS_WIDTH bits, wraps all-ones -> 0 on the last ack.
//  - stall=1 in every state except S_IDLE-with-hit / S_IDLE-idle.
//  - Bus outputs registered from next_state/next word_count so address is stable in the ack cycle.
//  - Miss latency with zero-wait memory: clean = 2^LWW+2 cycles; dirty = 2*2^LWW+3 cycles.
// CONFIGURATION
//  CMU_STATS_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0]; +1 per S_IDLE hit/miss
//    evaluation (re-evaluation after fill counts as hit), wrap at 2^32, cleared by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (SET_BITS=4, LINE_WORDS_WIDTH=2, zero-wait memory, mem[a]=a^32'hA5A5_0000)
//  1 rst, read 0x40 -> stall, fill reads 0x40,0x44,0x48,0x4C, no bus writes; then data_r=0xA5A5_0040, stall=0.
//  2 then read 0x4C -> hit same cycle, stall=0, data_r=0xA5A5_004C, mem_cs_o stays 0.
//  3 write 0x40=0xDEADBEEF, read 0x440 (set 4, way1, no write-back), read 0x840 -> write-back
//    0x40..0x4C with first word 0xDEADBEEF, then fill 0x840..0x84C; read 0x440 still hits.
//  4 en_r=en_w=1 addr 0x44 data 0x1234 -> treated as write; later read 0x44 returns 0x1234.
//  5 rst asserted during S_FILL word 2 -> next cycle mem_cs_o=0; re-read of same line misses, full refill.
//  6 CMU_STATS_EN: sequence of tests 1-2 -> miss_cnt=1, hit_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/cmu_2way_if.sv
// CPU-side request/response and word-wide memory bus of the 2-way CMU.
// slave = the CMU's view, master = the CPU/memory environment's view.
interface cmu_2way_if;
  logic [31:0] addr_rw;
  logic        en_r;
  logic        en_w;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  modport slave (
    input  addr_rw, en_r, en_w, data_w, mem_data_i, mem_ack_i,
    output data_r, stall, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output addr_rw, en_r, en_w, data_w, mem_data_i, mem_ack_i,
    input  data_r, stall, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/cmu_2way.sv
// 2-way set-associative write-back/write-allocate CMU with LRU replacement.
// Define CMU_STATS_EN to add the hit_cnt/miss_cnt counter outputs.
module cmu_2way #(
  parameter int LINE_WORDS_WIDTH = 2,
  parameter int SET_BITS         = 4
) (
  input  logic        clk,
  input  logic        rst,
  cmu_2way_if.slave   bus
`ifdef CMU_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int TAG_BITS = 32 - SET_BITS - LINE_WORDS_WIDTH - 2;
  localparam int WORDS    = 1 << LINE_WORDS_WIDTH;
  localparam int SETS     = 1 << SET_BITS;
  localparam int IDX_LO   = LINE_WORDS_WIDTH + 2;
  localparam int RAM_AW   = SET_BITS + LINE_WORDS_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_BACK, S_BACK_WAIT, S_FILL, S_FILL_WAIT} state_t;

  state_t                      state_q, state_d;
  logic [LINE_WORDS_WIDTH-1:0] cnt_q, cnt_d;
  logic                        victim_q, victim_d;
  logic [SETS-1:0]             lru_q;
  logic                        mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [31:0]                 mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;

  logic [TAG_BITS-1:0]         req_tag;
  logic [SET_BITS-1:0]         req_idx;
  logic [LINE_WORDS_WIDTH-1:0] req_word;
  logic                        req, ack, last_word, hit, hit_way, victim_sel;

  logic [1:0]                  way_hit, way_valid, way_dirty;
  logic [1:0][TAG_BITS-1:0]    way_tag;
  logic [1:0][31:0]            rd_word, wb_word;

  logic                        ram_we, ram_way, hit_wr, lru_upd, fill_done;
  logic [RAM_AW-1:0]           ram_addr;
  logic [31:0]                 ram_wdata;

  wire unused_addr_lsb = ^bus.addr_rw[1:0];

  assign req_tag   = bus.addr_rw[31:IDX_LO+SET_BITS];
  assign req_idx   = bus.addr_rw[IDX_LO+SET_BITS-1:IDX_LO];
  assign req_word  = bus.addr_rw[IDX_LO-1:2];
  assign req       = bus.en_r | bus.en_w;
  assign ack       = bus.mem_ack_i & mem_cs_q;
  assign last_word = (cnt_q == '1);
  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  // Invalid ways are filled before anything valid gets evicted.
  assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_idx]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      localparam logic WAY = (gi == 1);
      logic [31:0]         data_ram [SETS*WORDS];
      logic [TAG_BITS-1:0] tag_ram  [SETS];
      logic [SETS-1:0]     valid_q, dirty_q;

      always_ff @(posedge clk) begin
        if (!rst && ram_we && ram_way == WAY)
          data_ram[ram_addr] <= ram_wdata;
        if (fill_done && victim_q == WAY)
          tag_ram[req_idx] <= req_tag;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          dirty_q <= '0;
        end else if (fill_done && victim_q == WAY) begin
          valid_q[req_idx] <= 1'b1;
          dirty_q[req_idx] <= 1'b0;
        end else if (hit_wr && hit_way == WAY) begin
          dirty_q[req_idx] <= 1'b1;
        end
      end

      assign way_hit[gi]   = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);
      assign way_valid[gi] = valid_q[req_idx];
      assign way_dirty[gi] = dirty_q[req_idx];
      assign way_tag[gi]   = tag_ram[req_idx];
      assign rd_word[gi]   = data_ram[{req_idx, req_word}];
      assign wb_word[gi]   = data_ram[{req_idx, cnt_d}];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      lru_q <= '0;
    else if (lru_upd)
      lru_q[req_idx] <= ~hit_way;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      victim_q   <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      victim_q   <= victim_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    victim_d  = victim_q;
    ram_we    = 1'b0;
    ram_way   = victim_q;
    ram_addr  = {req_idx, req_word};
    ram_wdata = bus.data_w;
    hit_wr    = 1'b0;
    lru_upd   = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            lru_upd = 1'b1;
            if (bus.en_w) begin
              hit_wr  = 1'b1;
              ram_we  = 1'b1;
              ram_way = hit_way;
            end
          end else begin
            victim_d = victim_sel;
            cnt_d    = '0;
            state_d  = (way_valid[victim_sel] && way_dirty[victim_sel]) ? S_BACK : S_FILL;
          end
        end
      end
      S_BACK: begin
        if (ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = S_BACK_WAIT;
        end
      end
      S_BACK_WAIT: begin
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (ack) begin
          ram_we    = 1'b1;
          ram_addr  = {req_idx, cnt_q};
          ram_wdata = bus.mem_data_i;
          cnt_d     = cnt_q + 1'b1;
          if (last_word) state_d = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus registers follow the next state so the address is already stable in the ack cycle.
  always_comb begin : bus_next
    mem_cs_d   = (state_d == S_BACK) || (state_d == S_FILL);
    mem_we_d   = (state_d == S_BACK);
    mem_addr_d = '0;
    mem_data_d = '0;
    if (state_d == S_BACK) begin
      mem_addr_d = {way_tag[victim_d], req_idx, cnt_d, 2'b00};
      mem_data_d = wb_word[victim_d];
    end else if (state_d == S_FILL) begin
      mem_addr_d = {bus.addr_rw[31:IDX_LO], cnt_d, 2'b00};
    end
  end

  assign bus.data_r     = rd_word[hit_way];
  assign bus.stall      = !((state_q == S_IDLE) && (!req || hit));
  assign bus.mem_cs_o   = mem_cs_q;
  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_data_o = mem_data_q;

`ifdef CMU_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
